// File: rtl/ex_div.sv
// Execute-stage radix-2 restoring divider for DIV/DIVU.
// Produces the quotient for LO and the remainder for HI, and stalls F/D/E while it iterates.
module ex_div #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flushE,
  input  logic             div_startE,
  input  logic             div_signedE,
  input  logic             holdE,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             div_stallE,
  output logic             div_readyE,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_trial;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;

  // Operand magnitudes; only DIV takes absolute values.
  assign a_abs = (div_signedE && a_i[WIDTH-1]) ? WIDTH'(-a_i) : a_i;
  assign b_abs = (div_signedE && b_i[WIDTH-1]) ? WIDTH'(-b_i) : b_i;

  // One restoring step: shift next dividend bit into the partial remainder, trial subtract.
  assign rem_sh    = {rem_q, dvd_q[WIDTH-1]};
  assign no_borrow = (rem_sh >= {1'b0, dvs_q});
  assign rem_trial = WIDTH'(rem_sh - {1'b0, dvs_q});
  assign rem_nxt   = no_borrow ? rem_trial : rem_sh[WIDTH-1:0];
  assign dvd_nxt   = {dvd_q[WIDTH-2:0], no_borrow};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_startE && !flushE) begin
          state_d = BUSY;
          dvd_d   = a_abs;
          dvs_d   = b_abs;
          qsign_d = div_signedE & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rsign_d = div_signedE & a_i[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        rem_d = rem_nxt;
        dvd_d = dvd_nxt;
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quot_d  = qsign_q ? WIDTH'(-dvd_nxt) : dvd_nxt;
          remo_d  = rsign_q ? WIDTH'(-rem_nxt) : rem_nxt;
          state_d = DONE;
          ready_d = 1'b1;
        end
      end
      DONE: begin
        // Held instruction stays in E; start is still asserted but must not retrigger.
        if (holdE) ready_d = 1'b1;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flushE) begin
      state_d = IDLE;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      ready_q <= ready_d;
    end
  end

  assign div_stallE  = ~rst & (((state_q == IDLE) & div_startE & ~flushE) | (state_q == BUSY));
  assign div_readyE  = ready_q;
  assign quotient_o  = quot_q;
  assign remainder_o = remo_q;

endmodule

// File: tb/tb_ex_div.sv
// Randomized self-checking bench for ex_div against an arithmetic MIPS DIV/DIVU model.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        flushE, div_startE, div_signedE, holdE;
  logic [31:0] a_i, b_i;
  logic        div_stallE, div_readyE;
  logic [31:0] quotient_o, remainder_o;

  int checks = 0;
  int failures = 0;

  ex_div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flushE(flushE), .div_startE(div_startE),
    .div_signedE(div_signedE), .holdE(holdE), .a_i(a_i), .b_i(b_i),
    .div_stallE(div_stallE), .div_readyE(div_readyE),
    .quotient_o(quotient_o), .remainder_o(remainder_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: MIPS semantics, truncating quotient, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (!sgn) begin
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      return {a / b, a % b};
    end
    if (b == 32'd0) return {(a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF), a};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  // Issue one divide, optionally holding DONE for hold_n cycles; checks timing and results.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int hold_n);
    logic [63:0] exp;
    int n, stalls;
    exp = ref_div(a, b, sgn);
    @(negedge clk);
    a_i = a; b_i = b; div_signedE = sgn; div_startE = 1'b1; holdE = 1'b0;
    #1 check("stall_start", 64'(div_stallE), 64'd1);
    n = 0; stalls = 1;
    while (1) begin
      @(negedge clk);
      n++;
      a_i = $urandom; b_i = $urandom;
      if (div_readyE || n >= 40) break;
      stalls += int'(div_stallE);
    end
    check("latency", 64'(n), 64'd33);
    check("stall_cycles", 64'(stalls), 64'd33);
    check("quotient", 64'(quotient_o), 64'(exp[63:32]));
    check("remainder", 64'(remainder_o), 64'(exp[31:0]));
    check("stall_done", 64'(div_stallE), 64'd0);
    if (hold_n > 0) begin
      holdE = 1'b1;
      for (int k = 1; k < hold_n; k++) begin
        @(negedge clk);
        check("hold_ready", 64'(div_readyE), 64'd1);
        check("hold_stall", 64'(div_stallE), 64'd0);
        check("hold_result", {quotient_o, remainder_o}, exp);
      end
    end
    holdE = 1'b0;
    div_startE = 1'b0;
    @(negedge clk);
    check("ready_clear", 64'(div_readyE), 64'd0);
    check("idle_stall", 64'(div_stallE), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b, q_old, r_old;
    logic        sgn;
    rst = 1'b1; flushE = 1'b0; div_startE = 1'b1; div_signedE = 1'b0; holdE = 1'b0;
    a_i = 32'd100; b_i = 32'd7;
    #12;
    check("rst_quotient", 64'(quotient_o), 64'd0);
    check("rst_remainder", 64'(remainder_o), 64'd0);
    check("rst_ready", 64'(div_readyE), 64'd0);
    check("rst_stall", 64'(div_stallE), 64'd0);
    @(negedge clk);
    div_startE = 1'b0;
    rst = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, 0);
    run_div(32'hFFFF_FF9C, 32'd7, 1'b1, 0);
    run_div(32'd100, 32'hFFFF_FFF9, 1'b1, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_div(32'd5, 32'd0, 1'b0, 0);
    run_div(32'hFFFF_FF9C, 32'd0, 1'b1, 0);
    run_div(32'd77, 32'd0, 1'b1, 0);
    run_div(32'd1234567, 32'd89, 1'b0, 3);

    // Flush mid-BUSY at T+10: instruction dropped, results untouched.
    q_old = quotient_o; r_old = remainder_o;
    @(negedge clk);
    a_i = 32'd100; b_i = 32'd7; div_signedE = 1'b0; div_startE = 1'b1;
    repeat (10) @(negedge clk);
    flushE = 1'b1; div_startE = 1'b0;
    @(negedge clk);
    flushE = 1'b0;
    #1 check("flush_stall", 64'(div_stallE), 64'd0);
    check("flush_ready", 64'(div_readyE), 64'd0);
    check("flush_result", {quotient_o, remainder_o}, {q_old, r_old});
    repeat (30) begin
      @(negedge clk);
      if (div_readyE) check("flush_no_ready", 64'(div_readyE), 64'd0);
    end

    // Start in the same cycle as a flush: no stall, nothing starts.
    @(negedge clk);
    div_startE = 1'b1; flushE = 1'b1;
    #1 check("flush_start_stall", 64'(div_stallE), 64'd0);
    @(negedge clk);
    div_startE = 1'b0; flushE = 1'b0;
    #1 check("flush_start_idle", 64'(div_stallE), 64'd0);
    repeat (34) @(negedge clk);
    check("flush_start_ready", 64'(div_readyE), 64'd0);
    check("flush_start_result", {quotient_o, remainder_o}, {q_old, r_old});

    // Asynchronous reset mid-BUSY zeroes outputs without waiting for a clock edge.
    @(negedge clk);
    a_i = 32'd100; b_i = 32'd7; div_signedE = 1'b0; div_startE = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_quotient", 64'(quotient_o), 64'd0);
    check("arst_remainder", 64'(remainder_o), 64'd0);
    check("arst_ready", 64'(div_readyE), 64'd0);
    check("arst_stall", 64'(div_stallE), 64'd0);
    div_startE = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_div(32'd9, 32'd3, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(3))
        0: b = $urandom;
        1: b = 32'($urandom_range(15, 1));
        2: b = 32'($urandom_range(16)) - 32'd8;
        default: b = a >> $urandom_range(31);
      endcase
      sgn = 1'($urandom_range(1));
      run_div(a, b, sgn, (i % 5 == 0) ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
